// File: rtl/axi_stream_tid_demux.sv
// axi_stream_tid_demux: splits a merged AXI Stream back into NUM_OUTPUTS streams.
// The destination stream number rides in the MSBs of axis_in_tid. It is stripped
// from the output TID, and the route is locked for the whole packet.
// Each output has a one-beat register slice.
//
// Optional feature macro: AXIS_DEMUX_DROP_EN
//   defined   : packets whose select is out of range are discarded and counted.
//   undefined : such packets go to output NUM_OUTPUTS-1.
//
// Ports:
//   aclk, areset        clock, asynchronous active-high reset
//   axis_in_*           merged input stream (tid carries select + output tid)
//   axis_out_*          NUM_OUTPUTS streams packed side by side, output k in slice k
//   drop_count          dropped packet count (AXIS_DEMUX_DROP_EN only)
`timescale 1ns / 1ps

module axi_stream_tid_demux #(
  parameter int AXIS_BUS_WIDTH     = 64,
  parameter int AXIS_OUT_TID_WIDTH = 1,
  parameter int AXIS_TDEST_WIDTH   = 1,
  parameter int AXIS_TUSER_WIDTH   = 1,
  parameter int NUM_OUTPUTS        = 4,
  parameter int SEL_WIDTH          = $clog2(NUM_OUTPUTS),
  parameter int AXIS_IN_TID_WIDTH  = AXIS_OUT_TID_WIDTH + SEL_WIDTH
) (
  input  logic                                       aclk,
  input  logic                                       areset,
  input  logic [AXIS_BUS_WIDTH-1:0]                  axis_in_tdata,
  input  logic [AXIS_BUS_WIDTH/8-1:0]                axis_in_tkeep,
  input  logic [AXIS_IN_TID_WIDTH-1:0]               axis_in_tid,
  input  logic [AXIS_TDEST_WIDTH-1:0]                axis_in_tdest,
  input  logic [AXIS_TUSER_WIDTH-1:0]                axis_in_tuser,
  input  logic                                       axis_in_tlast,
  input  logic                                       axis_in_tvalid,
  output logic                                       axis_in_tready,
  output logic [NUM_OUTPUTS*AXIS_BUS_WIDTH-1:0]      axis_out_tdata,
  output logic [NUM_OUTPUTS*(AXIS_BUS_WIDTH/8)-1:0]  axis_out_tkeep,
  output logic [NUM_OUTPUTS*AXIS_OUT_TID_WIDTH-1:0]  axis_out_tid,
  output logic [NUM_OUTPUTS*AXIS_TDEST_WIDTH-1:0]    axis_out_tdest,
  output logic [NUM_OUTPUTS*AXIS_TUSER_WIDTH-1:0]    axis_out_tuser,
  output logic [NUM_OUTPUTS-1:0]                     axis_out_tlast,
  output logic [NUM_OUTPUTS-1:0]                     axis_out_tvalid,
`ifdef AXIS_DEMUX_DROP_EN
  output logic [31:0]                                drop_count,
`endif
  input  logic [NUM_OUTPUTS-1:0]                     axis_out_tready
);

  localparam int KeepWidth = AXIS_BUS_WIDTH / 8;
  localparam logic [SEL_WIDTH-1:0] LastOut = SEL_WIDTH'(NUM_OUTPUTS - 1);

`ifdef AXIS_DEMUX_DROP_EN
  typedef enum logic [1:0] {PktStart, PktRoute, PktDrop} state_e;
`else
  typedef enum logic [1:0] {PktStart, PktRoute} state_e;
`endif

  state_e                state_q, state_d;
  logic [SEL_WIDTH-1:0]  route_q, route_d;
  logic [SEL_WIDTH-1:0]  sel;
  logic                  sel_oob;
  logic [SEL_WIDTH-1:0]  tgt;
  logic                  drop;
  logic                  accept;
  logic [NUM_OUTPUTS-1:0] load;

  assign sel     = axis_in_tid[AXIS_IN_TID_WIDTH-1 -: SEL_WIDTH];
  assign sel_oob = 32'(sel) >= 32'(NUM_OUTPUTS);

  // Start beats use their live select; later beats follow the latched route.
`ifdef AXIS_DEMUX_DROP_EN
  assign tgt  = (state_q == PktRoute) ? route_q : sel;
  assign drop = (state_q == PktDrop) || ((state_q == PktStart) && sel_oob);
`else
  assign tgt  = (state_q == PktRoute) ? route_q : (sel_oob ? LastOut : sel);
  assign drop = 1'b0;
`endif

  // Depends only on slice state and consumer ready, never on axis_in_tvalid.
  assign axis_in_tready = !areset &&
                          (drop || !axis_out_tvalid[tgt] || axis_out_tready[tgt]);
  assign accept = axis_in_tvalid && axis_in_tready;

  always_comb begin
    load = '0;
    for (int k = 0; k < NUM_OUTPUTS; k++) begin
      load[k] = accept && !drop && (tgt == SEL_WIDTH'(k));
    end
  end

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    if (accept) begin
      unique case (state_q)
        PktStart: begin
`ifdef AXIS_DEMUX_DROP_EN
          if (drop) begin
            if (!axis_in_tlast) state_d = PktDrop;
          end else begin
            route_d = tgt;
            if (!axis_in_tlast) state_d = PktRoute;
          end
`else
          route_d = tgt;
          if (!axis_in_tlast) state_d = PktRoute;
`endif
        end
        PktRoute: if (axis_in_tlast) state_d = PktStart;
`ifdef AXIS_DEMUX_DROP_EN
        PktDrop:  if (axis_in_tlast) state_d = PktStart;
`endif
        default:  state_d = PktStart;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= PktStart;
      route_q <= '0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

  // Output slices: a load wins over a drain so back-to-back beats have no bubble.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      axis_out_tvalid <= '0;
      axis_out_tdata  <= '0;
      axis_out_tkeep  <= '0;
      axis_out_tid    <= '0;
      axis_out_tdest  <= '0;
      axis_out_tuser  <= '0;
      axis_out_tlast  <= '0;
    end else begin
      for (int k = 0; k < NUM_OUTPUTS; k++) begin
        if (load[k]) begin
          axis_out_tvalid[k] <= 1'b1;
          axis_out_tdata[k*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH]       <= axis_in_tdata;
          axis_out_tkeep[k*KeepWidth +: KeepWidth]                 <= axis_in_tkeep;
          axis_out_tid[k*AXIS_OUT_TID_WIDTH +: AXIS_OUT_TID_WIDTH] <=
              axis_in_tid[AXIS_OUT_TID_WIDTH-1:0];
          axis_out_tdest[k*AXIS_TDEST_WIDTH +: AXIS_TDEST_WIDTH]   <= axis_in_tdest;
          axis_out_tuser[k*AXIS_TUSER_WIDTH +: AXIS_TUSER_WIDTH]   <= axis_in_tuser;
          axis_out_tlast[k] <= axis_in_tlast;
        end else if (axis_out_tready[k]) begin
          axis_out_tvalid[k] <= 1'b0;
        end
      end
    end
  end

`ifdef AXIS_DEMUX_DROP_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      drop_count <= '0;
    end else if (accept && drop && axis_in_tlast && (drop_count != 32'hFFFF_FFFF)) begin
      drop_count <= drop_count + 32'd1;
    end
  end
`endif

endmodule
